// File: rtl/fract_interpolator.sv
// fract_interpolator: fractional-rate I/Q upsampler core.
// Produces outputs at fs*4096/step by linearly interpolating between the two
// most recent input samples, weighted by a 12-bit phase accumulator.
// Optional build macro: FRACT_INTERP_ROUND_EN selects round-half-up for the
// interpolation result instead of floor truncation.
module fract_interpolator #(
  parameter logic [7:0] SR_STEP = 8'd129
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_din_i,
  input  logic [15:0] i_din_q,
  input  logic        i_din_vld,
  output logic        o_rdy,
  input  logic        i_rdy,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_set_stb,
  input  logic [7:0]  i_set_addr,
  input  logic [31:0] i_set_data
);

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    RUN,
    ADV
  } state_t;

  localparam logic [12:0] STEP_MAX = 13'h1000;

  state_t      state;
  logic [15:0] x0_i;
  logic [15:0] x0_q;
  logic [15:0] x1_i;
  logic [15:0] x1_q;
  logic [11:0] phase;
  logic [12:0] step;
  logic [12:0] sum;
  logic        slot_free;
  logic [15:0] y_i;
  logic [15:0] y_q;
  logic        unused_set_bits;

  // Only the low 12 bits of the settings word carry the step.
  assign unused_set_bits = ^i_set_data[31:12];

  // y = x0 + (d*mu >>> 12); the result always lies between x0 and x1, so
  // truncating to 16 bits never wraps.
  function automatic logic [15:0] interp(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [11:0] mu);
    logic signed [16:0] d;
    logic signed [29:0] p;
    d = $signed({b[15], b}) - $signed({a[15], a});
    p = $signed({{13{d[16]}}, d}) * $signed({18'd0, mu});
`ifdef FRACT_INTERP_ROUND_EN
    p = p + 30'sd2048;
`endif
    return a + 16'(p >>> 12);
  endfunction

  // Interpolated outputs, phase accumulation and output-slot availability.
  always_comb begin
    y_i       = interp(x0_i, x1_i, phase);
    y_q       = interp(x0_q, x1_q, phase);
    sum       = {1'b0, phase} + step;
    slot_free = !o_tvalid || i_rdy;
  end

  // Upstream ready is a pure decode of the state.
  always_comb begin
    o_rdy = (state != RUN);
  end

  // Control FSM, sample history, phase/step registers and output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FILL0;
      x0_i     <= '0;
      x0_q     <= '0;
      x1_i     <= '0;
      x1_q     <= '0;
      phase    <= '0;
      step     <= STEP_MAX;
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
    end else begin
      if (i_set_stb && (i_set_addr == SR_STEP)) begin
        step <= (i_set_data[11:0] == 12'd0) ? STEP_MAX : {1'b0, i_set_data[11:0]};
      end

      if (o_tvalid && i_rdy) begin
        o_tvalid <= 1'b0;
      end

      case (state)
        FILL0: begin
          if (i_din_vld) begin
            x1_i  <= i_din_i;
            x1_q  <= i_din_q;
            state <= FILL1;
          end
        end
        FILL1: begin
          if (i_din_vld) begin
            x0_i  <= x1_i;
            x0_q  <= x1_q;
            x1_i  <= i_din_i;
            x1_q  <= i_din_q;
            phase <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (slot_free) begin
            o_tdata  <= {y_i, y_q};
            o_tvalid <= 1'b1;
            phase    <= sum[11:0];
            if (sum[12]) begin
              state <= ADV;
            end
          end
        end
        ADV: begin
          if (i_din_vld) begin
            x0_i  <= x1_i;
            x0_q  <= x1_q;
            x1_i  <= i_din_i;
            x1_q  <= i_din_q;
            state <= RUN;
          end
        end
        default: state <= FILL0;
      endcase
    end
  end

endmodule
